wb_stage: RTL and testbench

Dual-issue writeback stage sitting between the MEM stage and the two-write-port register file. It registers one retiring bundle (slot 1 older, slot 2 younger) per accepted handshake and aligns and sign-extends load data. It drives both register-file write ports in the bundle's first resident cycle. It also serialises the bundle onto the single-commit debug trace port, applying back-pressure to MEM for one cycle when both slots retire together.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_load_align.sv | 38 +++
 rtl/wb_stage.sv | 189 ++++++++++++++++++
 tb/tb_wb_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the dual-issue writeback stage.
//   - load-type encodings carried on mem_ldtype_iN
//   - writeback FSM state encoding
//   - default data / register-index widths
package wb_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_BU = 3'd1,
        LD_H  = 3'd2,
        LD_HU = 3'd3,
        LD_W  = 3'd4
    } ldtype_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no bundle resident
        ST_S1    = 2'd1,   // bundle resident, tracing first valid slot
        ST_S2    = 2'd2    // tracing slot 2 of a dual bundle
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment for one retiring slot (purely combinational).
// Ports:
//   ldtype  in   3       LB/LBU/LH/LHU/LW, reserved codes behave as LW
//   ldoff   in   2       byte offset addr[1:0]
//   raw     in   DATA_W  aligned word read from data RAM
//   data    out  DATA_W  selected, sign/zero-extended load value
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        ldtype,
    input  logic [1:0]        ldoff,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw[{ldoff, 3'b000} +: 8];
    // Halfword select only looks at ldoff[1]; a misaligned ldoff[0] is ignored.
    assign half_sel = ldoff[1] ? raw[31:16] : raw[15:0];

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        data = raw;
        case (ldtype)
            LD_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   data = {{(DATA_W-16){1'b0}}, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Dual-issue writeback stage between MEM and the two-write-port register file.
// Captures one retiring bundle (slot 1 older, slot 2 younger) per accepted
// handshake, drives both RF write ports in the bundle's first resident cycle
// and serialises the bundle onto the single-commit debug trace port.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   mem_valid / wb_ready           MEM -> WB handshake
//   mem_*_i1 / mem_*_i2            per-slot retiring instruction fields
//   we_iN, waddr_iN, wdata_iN      register-file write ports
//   debug_wb_*                     single-commit trace port
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               mem_valid,
    output logic               wb_ready,

    input  logic               mem_v_i1,
    input  logic               mem_we_i1,
    input  logic [RADDR_W-1:0] mem_waddr_i1,
    input  logic [DATA_W-1:0]  mem_res_i1,
    input  logic               mem_ld_i1,
    input  logic [2:0]         mem_ldtype_i1,
    input  logic [1:0]         mem_ldoff_i1,
    input  logic [DATA_W-1:0]  mem_ldata_i1,
    input  logic [31:0]        mem_pc_i1,

    input  logic               mem_v_i2,
    input  logic               mem_we_i2,
    input  logic [RADDR_W-1:0] mem_waddr_i2,
    input  logic [DATA_W-1:0]  mem_res_i2,
    input  logic               mem_ld_i2,
    input  logic [2:0]         mem_ldtype_i2,
    input  logic [1:0]         mem_ldoff_i2,
    input  logic [DATA_W-1:0]  mem_ldata_i2,
    input  logic [31:0]        mem_pc_i2,

    output logic               we_i1,
    output logic [RADDR_W-1:0] waddr_i1,
    output logic [DATA_W-1:0]  wdata_i1,
    output logic               we_i2,
    output logic [RADDR_W-1:0] waddr_i2,
    output logic [DATA_W-1:0]  wdata_i2,

    output logic [31:0]        debug_wb_pc,
    output logic [3:0]         debug_wb_rf_wen,
    output logic [RADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

    wb_state_e state, state_nxt;

    // Resident bundle.
    logic               r_v1, r_v2;
    logic               r_we1, r_we2;
    logic [RADDR_W-1:0] r_waddr1, r_waddr2;
    logic [DATA_W-1:0]  r_data1, r_data2;
    logic [31:0]        r_pc1, r_pc2;

    logic [DATA_W-1:0]  aligned1, aligned2;
    logic               accept;
    logic               both_v;
    logic               wr1_ok, wr2_ok;
    logic               collide;

    wb_load_align #(.DATA_W(DATA_W)) u_align1 (
        .ldtype (mem_ldtype_i1),
        .ldoff  (mem_ldoff_i1),
        .raw    (mem_ldata_i1),
        .data   (aligned1)
    );

    wb_load_align #(.DATA_W(DATA_W)) u_align2 (
        .ldtype (mem_ldtype_i2),
        .ldoff  (mem_ldoff_i2),
        .raw    (mem_ldata_i2),
        .data   (aligned2)
    );

    assign both_v  = r_v1 & r_v2;
    assign accept  = mem_valid & wb_ready;

    // Architectural writes of each resident slot (r0 is never written).
    assign wr1_ok  = r_v1 & r_we1 & (r_waddr1 != '0);
    assign wr2_ok  = r_v2 & r_we2 & (r_waddr2 != '0);
    // Both slots hitting the same register: the younger slot 2 wins.
    assign collide = wr1_ok & wr2_ok & (r_waddr1 == r_waddr2);

    // NOTE: state and bundle registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: bundle registers are reset as well: the RF address/data and trace
    // ports expose them directly, and they must read 0 out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_we1    <= 1'b0;
            r_we2    <= 1'b0;
            r_waddr1 <= '0;
            r_waddr2 <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
            r_pc1    <= '0;
            r_pc2    <= '0;
        end else if (accept) begin
            r_v1     <= mem_v_i1;
            r_v2     <= mem_v_i2;
            r_we1    <= mem_we_i1;
            r_we2    <= mem_we_i2;
            r_waddr1 <= mem_waddr_i1;
            r_waddr2 <= mem_waddr_i2;
            r_data1  <= mem_ld_i1 ? aligned1 : mem_res_i1;
            r_data2  <= mem_ld_i2 ? aligned2 : mem_res_i2;
            r_pc1    <= mem_pc_i1;
            r_pc2    <= mem_pc_i2;
        end
    end

    // Next state, handshake and trace selection.
    always_comb begin
        state_nxt         = state;
        wb_ready          = 1'b0;
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = 4'h0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;

        case (state)
            ST_EMPTY: begin
                wb_ready  = 1'b1;
                state_nxt = accept ? ST_S1 : ST_EMPTY;
            end
            ST_S1: begin
                // A dual bundle holds MEM off for its second trace cycle.
                wb_ready = ~both_v;
                if (both_v) begin
                    state_nxt = ST_S2;
                end else begin
                    state_nxt = accept ? ST_S1 : ST_EMPTY;
                end
                if (r_v1) begin
                    debug_wb_pc       = r_pc1;
                    debug_wb_rf_wen   = wr1_ok ? 4'hF : 4'h0;
                    debug_wb_rf_wnum  = r_waddr1;
                    debug_wb_rf_wdata = r_data1;
                end else begin
                    debug_wb_pc       = r_pc2;
                    debug_wb_rf_wen   = wr2_ok ? 4'hF : 4'h0;
                    debug_wb_rf_wnum  = r_waddr2;
                    debug_wb_rf_wdata = r_data2;
                end
            end
            ST_S2: begin
                wb_ready          = 1'b1;
                state_nxt         = accept ? ST_S1 : ST_EMPTY;
                debug_wb_pc       = r_pc2;
                debug_wb_rf_wen   = wr2_ok ? 4'hF : 4'h0;
                debug_wb_rf_wnum  = r_waddr2;
                debug_wb_rf_wdata = r_data2;
            end
            default: begin
                wb_ready  = 1'b1;
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // RF writes happen only in the first resident cycle of a bundle.
    assign we_i1    = (state == ST_S1) & wr1_ok & ~collide;
    assign we_i2    = (state == ST_S1) & wr2_ok;
    assign waddr_i1 = r_waddr1;
    assign waddr_i2 = r_waddr2;
    assign wdata_i1 = r_data1;
    assign wdata_i2 = r_data2;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
    import wb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam logic [31:0] RAW = 32'h80FF7F01;

    logic               clk;
    logic               resetn;
    logic               mem_valid;
    logic               wb_ready;
    logic               mem_v_i1, mem_we_i1, mem_ld_i1;
    logic [RADDR_W-1:0] mem_waddr_i1;
    logic [DATA_W-1:0]  mem_res_i1, mem_ldata_i1;
    logic [2:0]         mem_ldtype_i1;
    logic [1:0]         mem_ldoff_i1;
    logic [31:0]        mem_pc_i1;
    logic               mem_v_i2, mem_we_i2, mem_ld_i2;
    logic [RADDR_W-1:0] mem_waddr_i2;
    logic [DATA_W-1:0]  mem_res_i2, mem_ldata_i2;
    logic [2:0]         mem_ldtype_i2;
    logic [1:0]         mem_ldoff_i2;
    logic [31:0]        mem_pc_i2;
    logic               we_i1, we_i2;
    logic [RADDR_W-1:0] waddr_i1, waddr_i2;
    logic [DATA_W-1:0]  wdata_i1, wdata_i2;
    logic [31:0]        debug_wb_pc;
    logic [3:0]         debug_wb_rf_wen;
    logic [RADDR_W-1:0] debug_wb_rf_wnum;
    logic [DATA_W-1:0]  debug_wb_rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_valid         (mem_valid),
        .wb_ready          (wb_ready),
        .mem_v_i1          (mem_v_i1),
        .mem_we_i1         (mem_we_i1),
        .mem_waddr_i1      (mem_waddr_i1),
        .mem_res_i1        (mem_res_i1),
        .mem_ld_i1         (mem_ld_i1),
        .mem_ldtype_i1     (mem_ldtype_i1),
        .mem_ldoff_i1      (mem_ldoff_i1),
        .mem_ldata_i1      (mem_ldata_i1),
        .mem_pc_i1         (mem_pc_i1),
        .mem_v_i2          (mem_v_i2),
        .mem_we_i2         (mem_we_i2),
        .mem_waddr_i2      (mem_waddr_i2),
        .mem_res_i2        (mem_res_i2),
        .mem_ld_i2         (mem_ld_i2),
        .mem_ldtype_i2     (mem_ldtype_i2),
        .mem_ldoff_i2      (mem_ldoff_i2),
        .mem_ldata_i2      (mem_ldata_i2),
        .mem_pc_i2         (mem_pc_i2),
        .we_i1             (we_i1),
        .waddr_i1          (waddr_i1),
        .wdata_i1          (wdata_i1),
        .we_i2             (we_i2),
        .waddr_i2          (waddr_i2),
        .wdata_i2          (wdata_i2),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mem_valid     = 1'b0;
        mem_v_i1      = 1'b0; mem_we_i1 = 1'b0; mem_ld_i1 = 1'b0;
        mem_waddr_i1  = '0;   mem_res_i1 = '0;  mem_ldata_i1 = '0;
        mem_ldtype_i1 = '0;   mem_ldoff_i1 = '0; mem_pc_i1 = '0;
        mem_v_i2      = 1'b0; mem_we_i2 = 1'b0; mem_ld_i2 = 1'b0;
        mem_waddr_i2  = '0;   mem_res_i2 = '0;  mem_ldata_i2 = '0;
        mem_ldtype_i2 = '0;   mem_ldoff_i2 = '0; mem_pc_i2 = '0;
    endtask

    task automatic set_s1(input logic we, input logic [4:0] wa, input logic [31:0] res,
                          input logic ld, input logic [2:0] lt, input logic [1:0] lo,
                          input logic [31:0] pc);
        mem_v_i1 = 1'b1; mem_we_i1 = we; mem_waddr_i1 = wa; mem_res_i1 = res;
        mem_ld_i1 = ld; mem_ldtype_i1 = lt; mem_ldoff_i1 = lo;
        mem_ldata_i1 = RAW; mem_pc_i1 = pc;
    endtask

    task automatic set_s2(input logic we, input logic [4:0] wa, input logic [31:0] res,
                          input logic ld, input logic [2:0] lt, input logic [1:0] lo,
                          input logic [31:0] pc);
        mem_v_i2 = 1'b1; mem_we_i2 = we; mem_waddr_i2 = wa; mem_res_i2 = res;
        mem_ld_i2 = ld; mem_ldtype_i2 = lt; mem_ldoff_i2 = lo;
        mem_ldata_i2 = RAW; mem_pc_i2 = pc;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"}, {31'd0, wb_ready},  32'd1);
        check({tag, ".we1"},   {31'd0, we_i1},     32'd0);
        check({tag, ".we2"},   {31'd0, we_i2},     32'd0);
        check({tag, ".wen"},   {28'd0, debug_wb_rf_wen}, 32'd0);
    endtask

    // Load vectors: ldtype, ldoff, expected aligned value.
    logic [2:0]  ld_t [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd3, 3'd7};
    logic [1:0]  ld_o [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] ld_e [8] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                              32'h80FF7F01, 32'h0000007F, 32'h000080FF, 32'h80FF7F01};

    initial begin
        int accepts;
        resetn = 1'b0;
        clear_in();
        repeat (2) tick();

        // Reset state.
        check("rst.ready", {31'd0, wb_ready}, 32'd1);
        check("rst.we1",   {31'd0, we_i1},    32'd0);
        check("rst.we2",   {31'd0, we_i2},    32'd0);
        check("rst.wdata1", wdata_i1, 32'd0);
        check("rst.pc",    debug_wb_pc,       32'd0);
        check("rst.wen",   {28'd0, debug_wb_rf_wen}, 32'd0);
        resetn = 1'b1;
        tick();

        // Single slot-1 ALU write.
        set_s1(1'b1, 5'd3, 32'h1234, 1'b0, 3'd0, 2'd0, 32'h100);
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("alu.we1",    {31'd0, we_i1}, 32'd1);
        check("alu.waddr1", {27'd0, waddr_i1}, 32'd3);
        check("alu.wdata1", wdata_i1, 32'h1234);
        check("alu.we2",    {31'd0, we_i2}, 32'd0);
        check("alu.wen",    {28'd0, debug_wb_rf_wen}, 32'hF);
        check("alu.wnum",   {27'd0, debug_wb_rf_wnum}, 32'd3);
        check("alu.pc",     debug_wb_pc, 32'h100);
        check("alu.ready",  {31'd0, wb_ready}, 32'd1);
        tick();
        check_idle("alu.drain");

        // Dual bundle, r4 / r5.
        set_s1(1'b1, 5'd4, 32'h44, 1'b0, 3'd0, 2'd0, 32'h200);
        set_s2(1'b1, 5'd5, 32'h55, 1'b0, 3'd0, 2'd0, 32'h204);
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("dual.s1.we1",   {31'd0, we_i1}, 32'd1);
        check("dual.s1.we2",   {31'd0, we_i2}, 32'd1);
        check("dual.s1.wdata2", wdata_i2, 32'h55);
        check("dual.s1.ready", {31'd0, wb_ready}, 32'd0);
        check("dual.s1.pc",    debug_wb_pc, 32'h200);
        check("dual.s1.wnum",  {27'd0, debug_wb_rf_wnum}, 32'd4);
        check("dual.s1.wdata", debug_wb_rf_wdata, 32'h44);
        tick();
        check("dual.s2.we1",   {31'd0, we_i1}, 32'd0);
        check("dual.s2.we2",   {31'd0, we_i2}, 32'd0);
        check("dual.s2.ready", {31'd0, wb_ready}, 32'd1);
        check("dual.s2.pc",    debug_wb_pc, 32'h204);
        check("dual.s2.wnum",  {27'd0, debug_wb_rf_wnum}, 32'd5);
        check("dual.s2.wdata", debug_wb_rf_wdata, 32'h55);
        check("dual.s2.wen",   {28'd0, debug_wb_rf_wen}, 32'hF);
        tick();
        check_idle("dual.drain");

        // Back-to-back dual stream: one accept every two cycles.
        set_s1(1'b1, 5'd1, 32'h11, 1'b0, 3'd0, 2'd0, 32'h300);
        set_s2(1'b1, 5'd2, 32'h22, 1'b0, 3'd0, 2'd0, 32'h304);
        mem_valid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            if (wb_ready) accepts++;
            tick();
        end
        clear_in();
        check("stream.accepts", accepts, 32'd3);
        check("stream.s2.pc", debug_wb_pc, 32'h304);
        tick();
        check_idle("stream.drain");

        // Load alignment on 0x80FF7F01, streamed one single-slot bundle per cycle.
        for (int i = 0; i < 8; i++) begin
            clear_in();
            set_s1(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b1, ld_t[i], ld_o[i], 32'h400 + 32'(i * 4));
            mem_valid = 1'b1;
            tick();
            check($sformatf("ld%0d.wdata1", i), wdata_i1, ld_e[i]);
            check($sformatf("ld%0d.trace", i),  debug_wb_rf_wdata, ld_e[i]);
            check($sformatf("ld%0d.ready", i),  {31'd0, wb_ready}, 32'd1);
        end
        // Slot-2-only load: trace shows slot 2 in S1.
        clear_in();
        set_s2(1'b1, 5'd9, 32'h0, 1'b1, 3'd0, 2'd2, 32'h500);
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("ld2.we2",    {31'd0, we_i2}, 32'd1);
        check("ld2.we1",    {31'd0, we_i1}, 32'd0);
        check("ld2.wdata2", wdata_i2, 32'hFFFFFFFF);
        check("ld2.wnum",   {27'd0, debug_wb_rf_wnum}, 32'd9);
        check("ld2.pc",     debug_wb_pc, 32'h500);
        tick();
        check_idle("ld.drain");

        // Same-destination collision on r7.
        set_s1(1'b1, 5'd7, 32'hA, 1'b0, 3'd0, 2'd0, 32'h600);
        set_s2(1'b1, 5'd7, 32'hB, 1'b0, 3'd0, 2'd0, 32'h604);
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("col.we1",    {31'd0, we_i1}, 32'd0);
        check("col.we2",    {31'd0, we_i2}, 32'd1);
        check("col.wdata2", wdata_i2, 32'hB);
        check("col.s1.wen", {28'd0, debug_wb_rf_wen}, 32'hF);
        check("col.s1.wdata", debug_wb_rf_wdata, 32'hA);
        tick();
        check("col.s2.wen", {28'd0, debug_wb_rf_wen}, 32'hF);
        check("col.s2.wdata", debug_wb_rf_wdata, 32'hB);
        check("col.s2.pc",  debug_wb_pc, 32'h604);
        tick();

        // Write to r0 is suppressed.
        set_s1(1'b1, 5'd0, 32'h77, 1'b0, 3'd0, 2'd0, 32'h700);
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("r0.we1", {31'd0, we_i1}, 32'd0);
        check("r0.wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        check("r0.pc",  debug_wb_pc, 32'h700);
        tick();

        // Empty bundle (both v=0) is still accepted.
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("nov.ready", {31'd0, wb_ready}, 32'd1);
        check("nov.wen",   {28'd0, debug_wb_rf_wen}, 32'd0);
        check("nov.we1",   {31'd0, we_i1}, 32'd0);
        tick();

        // Reset asserted while in S2.
        set_s1(1'b1, 5'd10, 32'hAA, 1'b0, 3'd0, 2'd0, 32'h800);
        set_s2(1'b1, 5'd11, 32'hBB, 1'b0, 3'd0, 2'd0, 32'h804);
        mem_valid = 1'b1;
        tick();
        clear_in();
        tick();
        check("s2rst.pre.pc", debug_wb_pc, 32'h804);
        resetn = 1'b0;
        #1;
        check("s2rst.ready", {31'd0, wb_ready}, 32'd1);
        check("s2rst.pc",    debug_wb_pc, 32'd0);
        check("s2rst.wen",   {28'd0, debug_wb_rf_wen}, 32'd0);
        check("s2rst.wnum",  {27'd0, debug_wb_rf_wnum}, 32'd0);
        check("s2rst.waddr2", {27'd0, waddr_i2}, 32'd0);
        check("s2rst.wdata2", wdata_i2, 32'd0);
        #2;
        resetn = 1'b1;
        set_s1(1'b1, 5'd12, 32'hC0FFEE, 1'b0, 3'd0, 2'd0, 32'h900);
        mem_valid = 1'b1;
        tick();
        clear_in();
        check("post.we1",    {31'd0, we_i1}, 32'd1);
        check("post.waddr1", {27'd0, waddr_i1}, 32'd12);
        check("post.wdata1", wdata_i1, 32'hC0FFEE);
        check("post.wen",    {28'd0, debug_wb_rf_wen}, 32'hF);
        tick();
        check_idle("post.drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
